// File: rtl/bip_data_mem_dumper.sv
// Streams BIP data memory words 0..last_addr to the UART transmitter, one byte at a time, MSB first.
// Every output is registered so the memory and UART see clean, glitch-free strobes.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for i_start; o_busy low
//   ST_READ  | o_mem_rd high for one cycle at the current address
//   ST_LATCH | registered read data is valid; capture it into the word register
//   ST_SEND  | o_tx_start high for one cycle with the top byte of the word
//   ST_WAIT  | hold the byte until i_tx_done, then next byte, next word or finish
//   ST_DONE  | o_done high for one cycle, then back to idle
module bip_data_mem_dumper #(
  parameter int NB_DATA          = 16,
  parameter int N_ADDR           = 1024,
  parameter int LOG2_N_DATA_ADDR = 10,
  parameter int NB_BYTE          = 8
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_start,
  input  logic [LOG2_N_DATA_ADDR-1:0] i_last_addr,
  output logic [LOG2_N_DATA_ADDR-1:0] o_mem_addr,
  output logic                        o_mem_rd,
  input  logic [NB_DATA-1:0]          i_mem_data,
  output logic [NB_BYTE-1:0]          o_tx_data,
  output logic                        o_tx_start,
  input  logic                        i_tx_done,
  output logic                        o_busy,
  output logic                        o_done
);

  localparam int N_BYTES = NB_DATA / NB_BYTE;
  localparam int NB_CNT  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [NB_CNT-1:0] LAST_BYTE = NB_CNT'(N_BYTES - 1);

  if ((NB_DATA % NB_BYTE) != 0 || N_ADDR > (2 ** LOG2_N_DATA_ADDR)) begin : g_bad_params
    $error("bip_data_mem_dumper: NB_DATA must be a multiple of NB_BYTE and N_ADDR must fit the address");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_LATCH,
    ST_SEND,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t                        state;
  logic [LOG2_N_DATA_ADDR-1:0]   addr;
  logic [LOG2_N_DATA_ADDR-1:0]   last_addr;
  logic [NB_DATA-1:0]            word;
  logic [NB_CNT-1:0]             byte_cnt;
  logic                          mem_rd;
  logic                          tx_start;
  logic                          busy;
  logic                          done;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      addr      <= '0;
      last_addr <= '0;
      word      <= '0;
      byte_cnt  <= '0;
      mem_rd    <= 1'b0;
      tx_start  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      mem_rd   <= 1'b0;
      tx_start <= 1'b0;
      done     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            last_addr <= i_last_addr;
            addr      <= '0;
            mem_rd    <= 1'b1;
            busy      <= 1'b1;
            state     <= ST_READ;
          end
        end
        ST_READ: state <= ST_LATCH;
        ST_LATCH: begin
          word     <= i_mem_data;
          byte_cnt <= '0;
          tx_start <= 1'b1;
          state    <= ST_SEND;
        end
        ST_SEND: state <= ST_WAIT;
        ST_WAIT: begin
          // addr stops at last_addr, so it can never wrap past the end of memory
          if (i_tx_done) begin
            if (byte_cnt != LAST_BYTE) begin
              word     <= word << NB_BYTE;
              byte_cnt <= byte_cnt + NB_CNT'(1);
              tx_start <= 1'b1;
              state    <= ST_SEND;
            end else if (addr != last_addr) begin
              addr   <= addr + LOG2_N_DATA_ADDR'(1);
              mem_rd <= 1'b1;
              state  <= ST_READ;
            end else begin
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_mem_addr = addr;
  assign o_mem_rd   = mem_rd;
  assign o_tx_data  = word[NB_DATA-1 -: NB_BYTE];
  assign o_tx_start = tx_start;
  assign o_busy     = busy;
  assign o_done     = done;

endmodule
